// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port synchronous data RAM (one-cycle read latency) between
// the CPU dmem port and a secondary requester (e.g. a sprite/VGA fetch engine).
// The CPU has fixed priority. A starvation counter forces the secondary port
// through after MAX_WAIT consecutive blocked cycles, stalling the CPU for that
// single cycle.
//
// Ports:
//   clock, reset            system clock, asynchronous active-high reset
//   cpu_req/wren/addr/wdata CPU access request (held by the CPU while stalled)
//   cpu_rdata               CPU load data, cycle after a granted CPU read
//   cpu_stall               CPU access not taken this cycle
//   ext_req/wren/addr/wdata secondary request (held until ext_gnt)
//   ext_gnt                 secondary access taken this cycle
//   ext_rvalid/ext_rdata    secondary read return, cycle after a granted read
//   ram_wEn/addr/dataIn     RAM request side
//   ram_dataOut             RAM read data (registered inside the RAM)
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wren,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_wren,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_gnt,
    output logic              ext_rvalid,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ram_wEn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
);

    // Who owns the RAM read data coming back this cycle.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU_RD = 2'd1,
        OWN_EXT_RD = 2'd2
    } owner_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    owner_t            owner_r;
    logic [3:0]        wait_cnt_r;
    logic [DATA_W-1:0] cpu_hold_r;

    logic force_s;
    logic cpu_win_s;
    logic ext_win_s;

    // Grant decision: CPU wins unless ext has starved for MAX_WAIT cycles.
    always_comb begin
        force_s   = (wait_cnt_r == MAX_WAIT_C);
        cpu_win_s = cpu_req & ~(ext_req & force_s);
        ext_win_s = ext_req & (~cpu_req | force_s);
    end

    // RAM request mux; an idle RAM sees all-zero address and data.
    always_comb begin
        ram_wEn    = 1'b0;
        ram_addr   = {ADDR_W{1'b0}};
        ram_dataIn = {DATA_W{1'b0}};
        if (cpu_win_s) begin
            ram_wEn    = cpu_wren;
            ram_addr   = cpu_addr;
            ram_dataIn = cpu_wdata;
        end else if (ext_win_s) begin
            ram_wEn    = ext_wren;
            ram_addr   = ext_addr;
            ram_dataIn = ext_wdata;
        end else begin
            ram_wEn    = 1'b0;
        end
    end

    // Handshake outputs towards both requesters.
    always_comb begin
        ext_gnt   = ext_win_s;
        cpu_stall = cpu_req & ext_win_s;
    end

    // Read return steering; the CPU sees its last load value between loads.
    always_comb begin
        if (owner_r == OWN_CPU_RD) begin
            cpu_rdata = ram_dataOut;
        end else begin
            cpu_rdata = cpu_hold_r;
        end
        ext_rvalid = (owner_r == OWN_EXT_RD);
        if (owner_r == OWN_EXT_RD) begin
            ext_rdata = ram_dataOut;
        end else begin
            ext_rdata = {DATA_W{1'b0}};
        end
    end

    // Owner tracking, CPU load-data hold and starvation counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_r    <= OWN_NONE;
            wait_cnt_r <= 4'd0;
            cpu_hold_r <= {DATA_W{1'b0}};
        end else begin
            // Only reads produce a return next cycle; writes and idle do not.
            if (cpu_win_s && !cpu_wren) begin
                owner_r <= OWN_CPU_RD;
            end else if (ext_win_s && !ext_wren) begin
                owner_r <= OWN_EXT_RD;
            end else begin
                owner_r <= OWN_NONE;
            end

            if (owner_r == OWN_CPU_RD) begin
                cpu_hold_r <= ram_dataOut;
            end else begin
                cpu_hold_r <= cpu_hold_r;
            end

            // A grant or a withdrawn request restarts the starvation count.
            if (ext_req && !ext_win_s) begin
                if (wait_cnt_r < MAX_WAIT_C) begin
                    wait_cnt_r <= wait_cnt_r + 4'd1;
                end else begin
                    wait_cnt_r <= wait_cnt_r;
                end
            end else begin
                wait_cnt_r <= 4'd0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_wren;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          ext_req, ext_wren;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt, ext_rvalid;
    logic [DW-1:0] ext_rdata;
    logic          ram_wEn;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_dataIn, ram_dataOut;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_wren(ext_wren), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid),
        .ext_rdata(ext_rdata), .ram_wEn(ram_wEn), .ram_addr(ram_addr),
        .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
    );

    always #5 clock = ~clock;

    // Single-port synchronous RAM behind the arbiter.
    logic [DW-1:0] mem [0:4095];
    always @(posedge clock) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= mem[ram_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: shadow memory, starvation count and one pending return.
    logic [DW-1:0] shadow [0:4095];
    int            m_wait;
    int            m_kind;      // 0 nothing, 1 CPU read, 2 ext read
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_hold;
    logic          m_force, m_cw, m_ew;
    logic          e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;

    // Compare process: checks every output against the model each cycle.
    always @(negedge clock) begin
        if (reset) begin
            m_wait = 0;
            m_kind = 0;
            m_data = 32'h0;
            m_hold = 32'h0;
        end else begin
            chk("m_cpu_rdata", cpu_rdata, (m_kind == 1) ? m_data : m_hold);
            chk("m_ext_rvalid", {31'b0, ext_rvalid}, (m_kind == 2) ? 32'd1 : 32'd0);
            chk("m_ext_rdata", ext_rdata, (m_kind == 2) ? m_data : 32'h0);
            if (m_kind == 1) m_hold = m_data;

            m_force = ext_req && (m_wait >= MW);
            m_cw    = cpu_req && !m_force;
            m_ew    = ext_req && !m_cw;
            e_wen   = (m_cw && cpu_wren) || (m_ew && ext_wren);
            e_addr  = m_cw ? cpu_addr  : (m_ew ? ext_addr  : 12'h000);
            e_din   = m_cw ? cpu_wdata : (m_ew ? ext_wdata : 32'h0);
            chk("m_ext_gnt", {31'b0, ext_gnt}, {31'b0, m_ew});
            chk("m_cpu_stall", {31'b0, cpu_stall}, {31'b0, cpu_req && m_ew});
            chk("m_ram_wEn", {31'b0, ram_wEn}, {31'b0, e_wen});
            chk("m_ram_addr", {20'b0, ram_addr}, {20'b0, e_addr});
            chk("m_ram_dataIn", ram_dataIn, e_din);

            m_kind = 0;
            if (m_cw) begin
                if (cpu_wren) shadow[cpu_addr] = cpu_wdata;
                else begin m_kind = 1; m_data = shadow[cpu_addr]; end
            end else if (m_ew) begin
                if (ext_wren) shadow[ext_addr] = ext_wdata;
                else begin m_kind = 2; m_data = shadow[ext_addr]; end
            end
            if (ext_req && !m_ew) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
            else m_wait = 0;
        end
    end

    // One cycle: drive inputs just after posedge, return at the negedge.
    task automatic step(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic er, input logic ew, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        @(posedge clock); #1;
        cpu_req = cr; cpu_wren = cw; cpu_addr = ca; cpu_wdata = cd;
        ext_req = er; ext_wren = ew; ext_addr = ea; ext_wdata = ed;
        @(negedge clock);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
    endtask

    logic cpu_stalled;
    logic ext_pending;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 32'hA500_0000 ^ (32'(i) * 32'd2654435);
            shadow[i] = 32'hA500_0000 ^ (32'(i) * 32'd2654435);
        end
        mem[12'h001] = 32'd7;         shadow[12'h001] = 32'd7;
        mem[12'h002] = 32'd9;         shadow[12'h002] = 32'd9;
        mem[12'h020] = 32'h0000_1234; shadow[12'h020] = 32'h0000_1234;

        reset = 1'b1;
        cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = 12'h000; cpu_wdata = 32'h0;
        ext_req = 1'b0; ext_wren = 1'b0; ext_addr = 12'h000; ext_wdata = 32'h0;

        // Reset state with no requests.
        @(negedge clock);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
        chk("rst_ext_rdata", ext_rdata, 32'h0);
        chk("rst_cpu_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_ext_gnt", {31'b0, ext_gnt}, 32'd0);
        chk("rst_ram_wEn", {31'b0, ram_wEn}, 32'd0);
        chk("rst_ram_addr", {20'b0, ram_addr}, 32'h0);
        chk("rst_ram_dataIn", ram_dataIn, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        // CPU only: store then load.
        step(1'b1, 1'b1, 12'h005, 32'h0000_00AB, 1'b0, 1'b0, 12'h000, 32'h0);
        chk("cpu_st_stall", {31'b0, cpu_stall}, 32'd0);
        chk("cpu_st_wEn", {31'b0, ram_wEn}, 32'd1);
        chk("cpu_st_gnt", {31'b0, ext_gnt}, 32'd0);
        step(1'b1, 1'b0, 12'h005, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        chk("cpu_ld_stall", {31'b0, cpu_stall}, 32'd0);
        chk("cpu_ld_addr", {20'b0, ram_addr}, 32'h005);
        idle();
        chk("cpu_ld_data", cpu_rdata, 32'h0000_00AB);

        // Ext only read.
        step(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h005, 32'h0);
        chk("ext_only_gnt", {31'b0, ext_gnt}, 32'd1);
        idle();
        chk("ext_only_rvalid", {31'b0, ext_rvalid}, 32'd1);
        chk("ext_only_rdata", ext_rdata, 32'h0000_00AB);
        idle();
        chk("ext_only_rvalid_off", {31'b0, ext_rvalid}, 32'd0);

        // Contention: ext forced through on the 5th blocked cycle.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 12'h040, 32'h0, 1'b1, 1'b0, 12'h020, 32'h0);
            chk("cont_gnt", {31'b0, ext_gnt}, (i == 5) ? 32'd1 : 32'd0);
            chk("cont_stall", {31'b0, cpu_stall}, (i == 5) ? 32'd1 : 32'd0);
        end
        step(1'b1, 1'b0, 12'h041, 32'h0, 1'b1, 1'b0, 12'h021, 32'h0);
        chk("cont_rvalid", {31'b0, ext_rvalid}, 32'd1);
        chk("cont_rdata", ext_rdata, 32'h0000_1234);
        chk("cont_no_restall", {31'b0, cpu_stall}, 32'd0);
        chk("cont_gnt_after", {31'b0, ext_gnt}, 32'd0);
        // Ext withdraws before grant: count restarts.
        step(1'b1, 1'b0, 12'h041, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        chk("drop_addr", {20'b0, ram_addr}, 32'h041);
        for (int j = 1; j <= 5; j++) begin
            step(1'b1, 1'b0, 12'h042, 32'h0, 1'b1, 1'b1, 12'h022, 32'hCAFE_0001);
            chk("drop_gnt", {31'b0, ext_gnt}, (j == 5) ? 32'd1 : 32'd0);
            chk("drop_wEn", {31'b0, ram_wEn}, (j == 5) ? 32'd1 : 32'd0);
        end
        idle();

        // Ordering across owners with no bubble.
        step(1'b1, 1'b0, 12'h001, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        chk("ord_c1_gnt", {31'b0, ext_gnt}, 32'd0);
        step(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h002, 32'h0);
        chk("ord_c2_cpu", cpu_rdata, 32'd7);
        chk("ord_c2_gnt", {31'b0, ext_gnt}, 32'd1);
        idle();
        chk("ord_c3_rvalid", {31'b0, ext_rvalid}, 32'd1);
        chk("ord_c3_rdata", ext_rdata, 32'd9);
        chk("ord_c3_cpu", cpu_rdata, 32'd7);

        // Ext write then CPU read of the same word.
        step(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b1, 12'h030, 32'h0000_DEAD);
        chk("wr_gnt", {31'b0, ext_gnt}, 32'd1);
        chk("wr_wEn", {31'b0, ram_wEn}, 32'd1);
        step(1'b1, 1'b0, 12'h030, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        chk("rd_wEn", {31'b0, ram_wEn}, 32'd0);
        chk("rd_stall", {31'b0, cpu_stall}, 32'd0);
        idle();
        chk("rd_data", cpu_rdata, 32'h0000_DEAD);

        // Reset while a CPU read is in flight.
        step(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, 1'b0, 12'h000, 32'h0);
        chk("rmid_addr", {20'b0, ram_addr}, 32'h010);
        #1;
        reset = 1'b1; cpu_req = 1'b0;
        #1;
        chk("rmid_cpu_rdata", cpu_rdata, 32'h0);
        chk("rmid_ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
        @(negedge clock);
        chk("rmid_hold", cpu_rdata, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rmid_no_stray", cpu_rdata, 32'h0);
        chk("rmid_no_rvalid", {31'b0, ext_rvalid}, 32'd0);

        // Reset while an ext read return is being presented.
        step(1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0, 12'h011, 32'h0);
        chk("rext_gnt", {31'b0, ext_gnt}, 32'd1);
        @(posedge clock); #1;
        ext_req = 1'b0;
        chk("rext_rvalid_pre", {31'b0, ext_rvalid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rext_rvalid_post", {31'b0, ext_rvalid}, 32'd0);
        chk("rext_rdata_post", ext_rdata, 32'h0);
        @(negedge clock);
        @(posedge clock); #1;
        reset = 1'b0;
        idle();
        idle();

        // Randomized traffic under the request-hold protocol.
        cpu_stalled = 1'b0;
        ext_pending = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clock); #1;
            if (!cpu_stalled) begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_wren  = ($urandom_range(0, 2) == 0);
                cpu_addr  = 12'($urandom_range(0, 31));
                cpu_wdata = $urandom;
            end
            if (ext_pending) begin
                if ($urandom_range(0, 15) == 0) ext_req = 1'b0;
            end else begin
                ext_req   = ($urandom_range(0, 2) == 0);
                ext_wren  = ($urandom_range(0, 2) == 0);
                ext_addr  = 12'($urandom_range(0, 31));
                ext_wdata = $urandom;
            end
            @(negedge clock);
            cpu_stalled = cpu_stall;
            ext_pending = ext_req && !ext_gnt;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
